// File: rtl/superscalar_pkg.sv
// Shared definitions for the 2-way in-order superscalar core.
// Contents:
//   - opcode constants
//   - instruction field positions
//   - default memory depth
//   - the decoded-instruction struct, with the decode, register-read and branch-compare helpers
package superscalar_pkg;

    localparam int unsigned MemDepthDefault = 1028;

    // Opcodes
    localparam logic [5:0] OpAdd  = 6'b000000;
    localparam logic [5:0] OpSub  = 6'b000001;
    localparam logic [5:0] OpMul  = 6'b000010;
    localparam logic [5:0] OpAnd  = 6'b000011;
    localparam logic [5:0] OpOr   = 6'b000100;
    localparam logic [5:0] OpXor  = 6'b000101;
    localparam logic [5:0] OpSll  = 6'b000110;
    localparam logic [5:0] OpSrl  = 6'b000111;
    localparam logic [5:0] OpAddi = 6'b001000;
    localparam logic [5:0] OpSubi = 6'b001001;
    localparam logic [5:0] OpAndi = 6'b001010;
    localparam logic [5:0] OpOri  = 6'b001011;
    localparam logic [5:0] OpXori = 6'b001100;
    localparam logic [5:0] OpLw   = 6'b010000;
    localparam logic [5:0] OpSw   = 6'b010001;
    localparam logic [5:0] OpBeq  = 6'b011000;
    localparam logic [5:0] OpBne  = 6'b011001;
    localparam logic [5:0] OpBlt  = 6'b011010;
    localparam logic [5:0] OpBge  = 6'b011011;
    localparam logic [5:0] OpJ    = 6'b100000;
    localparam logic [5:0] OpJal  = 6'b100001;
    localparam logic [5:0] OpNop  = 6'b111111;

    // Instruction field positions
    localparam int unsigned OpHi  = 31;
    localparam int unsigned OpLo  = 26;
    localparam int unsigned Rs1Hi = 25;
    localparam int unsigned Rs1Lo = 21;
    localparam int unsigned RtHi  = 20;
    localparam int unsigned RtLo  = 16;
    localparam int unsigned RdHi  = 15;
    localparam int unsigned RdLo  = 11;
    localparam int unsigned ImmHi = 15;
    localparam int unsigned TgtHi = 25;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rt;       // rs2 for R-type
        logic [31:0] imm;      // sign-extended
        logic [31:0] target;   // absolute jump target
        logic        is_r;
        logic        is_i;
        logic        is_lw;
        logic        is_sw;
        logic        is_br;
        logic        is_j;
        logic        is_jal;
        logic        wr_en;
        logic [4:0]  wr_addr;
    } decode_t;

    function automatic decode_t decode(input logic [31:0] ins);
        decode_t d;
        logic [4:0] rd;
        rd        = ins[RdHi:RdLo];
        d.op      = ins[OpHi:OpLo];
        d.rs1     = ins[Rs1Hi:Rs1Lo];
        d.rt      = ins[RtHi:RtLo];
        d.imm     = {{16{ins[ImmHi]}}, ins[ImmHi:0]};
        d.target  = {6'b0, ins[TgtHi:0]};
        d.is_r    = d.op inside {[OpAdd:OpSrl]};
        d.is_i    = d.op inside {[OpAddi:OpXori]};
        d.is_lw   = (d.op == OpLw);
        d.is_sw   = (d.op == OpSw);
        d.is_br   = d.op inside {[OpBeq:OpBge]};
        d.is_j    = (d.op == OpJ);
        d.is_jal  = (d.op == OpJal);
        d.wr_en   = d.is_r | d.is_i | d.is_lw | d.is_jal;
        d.wr_addr = d.is_r ? rd : (d.is_jal ? 5'd31 : d.rt);
        return d;
    endfunction

    // True when the instruction sources register r.
    function automatic logic reads_reg(input decode_t d, input logic [4:0] r);
        logic use_rs1, use_rt;
        use_rs1 = d.is_r | d.is_i | d.is_lw | d.is_sw | d.is_br;
        use_rt  = d.is_r | d.is_sw | d.is_br;
        return (use_rs1 && d.rs1 == r) || (use_rt && d.rt == r);
    endfunction

    function automatic logic branch_taken(input decode_t d, input logic [31:0] a,
                                          input logic [31:0] b);
        case (d.op)
            OpBeq:   return a == b;
            OpBne:   return a != b;
            OpBlt:   return $signed(a) < $signed(b);
            OpBge:   return $signed(a) >= $signed(b);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/superscalar_processor_alu.sv
// Single-slot ALU, one instance per issue slot.
// Ports:
//   op_i     - instruction opcode; register and immediate forms share datapaths.
//   a_i      - first operand (rs1 value).
//   b_i      - second operand (rs2 value or sign-extended immediate).
//   result_o - ALU result; zero for opcodes that are not ALU operations.
module ssp_alu
    import superscalar_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [5:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] result_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            OpAdd, OpAddi: result_o = a_i + b_i;
            OpSub, OpSubi: result_o = a_i - b_i;
            OpMul:         result_o = a_i * b_i;
            OpAnd, OpAndi: result_o = a_i & b_i;
            OpOr,  OpOri:  result_o = a_i | b_i;
            OpXor, OpXori: result_o = a_i ^ b_i;
            OpSll:         result_o = a_i << b_i[4:0];
            OpSrl:         result_o = a_i >> b_i[4:0];
            default:       result_o = '0;
        endcase
    end

endmodule

// File: rtl/superscalar_processor.sv
// 2-way in-order superscalar core with an internal register file (REG) and a unified
// instruction/data memory (MEM). Each cycle it fetches MEM[pc] and MEM[pc+1]. Both slots
// issue unless a hazard exists inside the pair, in which case only slot0 issues. Execute and
// writeback complete on the same edge as issue.
// Ports:
//   clk1      - sole clock.
//   reset     - synchronous, active-low reset.
//   pc        - current fetch address (word index).
//   issue_cnt - number of instructions retired on the last edge.
module superscalar_processor
    import superscalar_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = MemDepthDefault,
    parameter int unsigned XLEN      = 32
) (
    input  logic            clk1,
    input  logic            reset,
    output logic [XLEN-1:0] pc,
    output logic [1:0]      issue_cnt
);

    localparam int unsigned Aw = $clog2(MEM_DEPTH);

    logic [XLEN-1:0] REG [0:31];
    logic [XLEN-1:0] MEM [0:MEM_DEPTH-1];

    logic [XLEN-1:0] pc_q, pc_d, pc1;
    logic [1:0]      issue_cnt_q, issue_cnt_d;
    logic [XLEN-1:0] instr0, instr1;
    decode_t         d0, d1;
    logic [XLEN-1:0] a0, b0, a1, b1, alu_b0, alu_b1, alu_r0, alu_r1, res0, res1;
    logic [XLEN-1:0] mem_addr, ld_data, tgt0, tgt1;
    logic            mem_ok, taken0, taken1, dual;

    // Fetch; addresses past the end of memory read as NOP.
    assign pc1    = pc_q + 1;
    assign instr0 = (pc_q < MEM_DEPTH) ? MEM[pc_q[Aw-1:0]] : {OpNop, 26'b0};
    assign instr1 = (pc1 < MEM_DEPTH)  ? MEM[pc1[Aw-1:0]]  : {OpNop, 26'b0};
    assign d0     = decode(instr0);
    assign d1     = decode(instr1);

    // Both slots read operands from the pre-edge register state.
    assign a0     = REG[d0.rs1];
    assign b0     = REG[d0.rt];
    assign a1     = REG[d1.rs1];
    assign b1     = REG[d1.rt];
    assign alu_b0 = d0.is_r ? b0 : d0.imm;
    assign alu_b1 = d1.is_r ? b1 : d1.imm;

    ssp_alu #(.XLEN(XLEN)) u_alu0 (
        .op_i     (d0.op),
        .a_i      (a0),
        .b_i      (alu_b0),
        .result_o (alu_r0)
    );

    ssp_alu #(.XLEN(XLEN)) u_alu1 (
        .op_i     (d1.op),
        .a_i      (a1),
        .b_i      (alu_b1),
        .result_o (alu_r1)
    );

    // Single data port: at most one memory op issues per cycle, so one address is enough.
    assign mem_addr = (d0.is_lw || d0.is_sw) ? a0 + d0.imm : a1 + d1.imm;
    assign mem_ok   = mem_addr < MEM_DEPTH;
    assign ld_data  = mem_ok ? MEM[mem_addr[Aw-1:0]] : '0;

    assign res0 = d0.is_lw ? ld_data : (d0.is_jal ? pc_q + 1 : alu_r0);
    assign res1 = d1.is_lw ? ld_data : (d1.is_jal ? pc1 + 1 : alu_r1);

    assign taken0 = branch_taken(d0, a0, b0) | d0.is_j | d0.is_jal;
    assign taken1 = branch_taken(d1, a1, b1) | d1.is_j | d1.is_jal;
    assign tgt0   = d0.is_br ? pc_q + 1 + d0.imm : d0.target;
    assign tgt1   = d1.is_br ? pc1 + 1 + d1.imm : d1.target;

    // A write to R0 is dropped, so it creates no real dependency for slot1.
    assign dual = !((d0.wr_en && d0.wr_addr != 5'd0 && reads_reg(d1, d0.wr_addr)) ||
                    d0.is_br || d0.is_j || d0.is_jal ||
                    ((d0.is_lw || d0.is_sw) && (d1.is_lw || d1.is_sw)));

    always_comb begin
        pc_d        = pc_q + 1;
        issue_cnt_d = 2'd1;
        if (dual) begin
            issue_cnt_d = 2'd2;
            pc_d        = taken1 ? tgt1 : pc_q + 2;
        end else if (taken0) begin
            pc_d = tgt0;
        end
    end

    always_ff @(posedge clk1) begin
        if (!reset) begin
            pc_q        <= '0;
            issue_cnt_q <= 2'd0;
        end else begin
            pc_q        <= pc_d;
            issue_cnt_q <= issue_cnt_d;
            if (d0.wr_en && d0.wr_addr != 5'd0) REG[d0.wr_addr] <= res0;
            // Placed after slot0 so that slot1 wins a same-register write.
            if (dual && d1.wr_en && d1.wr_addr != 5'd0) REG[d1.wr_addr] <= res1;
            if (d0.is_sw && mem_ok) begin
                MEM[mem_addr[Aw-1:0]] <= b0;
            end else if (dual && d1.is_sw && mem_ok) begin
                MEM[mem_addr[Aw-1:0]] <= b1;
            end
        end
    end

    assign pc        = pc_q;
    assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_superscalar_processor.sv
// Self-checking bench for superscalar_processor. Expected pc/issue_cnt and register/memory
// values are queued before each clock edge and compared after it.
module tb_superscalar_processor;

    localparam logic [5:0] T_ADD = 6'b000000, T_SUB = 6'b000001, T_MUL = 6'b000010;
    localparam logic [5:0] T_AND = 6'b000011, T_OR = 6'b000100, T_XOR = 6'b000101;
    localparam logic [5:0] T_SLL = 6'b000110, T_SRL = 6'b000111, T_ADDI = 6'b001000;
    localparam logic [5:0] T_SUBI = 6'b001001, T_ANDI = 6'b001010, T_ORI = 6'b001011;
    localparam logic [5:0] T_XORI = 6'b001100, T_LW = 6'b010000, T_SW = 6'b010001;
    localparam logic [5:0] T_BEQ = 6'b011000, T_BNE = 6'b011001, T_BLT = 6'b011010;
    localparam logic [5:0] T_BGE = 6'b011011, T_J = 6'b100000, T_JAL = 6'b100001;
    localparam logic [31:0] NOP_W = 32'hFC00_0000;

    logic        clk1 = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc;
    logic [1:0]  issue_cnt;

    superscalar_processor #(.MEM_DEPTH(1028), .XLEN(32)) dut (
        .clk1      (clk1),
        .reset     (reset),
        .pc        (pc),
        .issue_cnt (issue_cnt)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        string       name;
        int          kind;   // 0 trace, 1 register, 2 memory
        int          idx;
        logic [31:0] exp_v;
        logic [1:0]  exp_c;
    } sb_t;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic        is_imm;
        logic [31:0] a;
        logic [31:0] b;      // low 16 bits are the immediate for I-type
        logic [31:0] exp_v;
    } vec_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    function automatic logic [31:0] r_ins(logic [5:0] op, logic [4:0] s1, logic [4:0] s2,
                                          logic [4:0] d);
        return {op, s1, s2, d, 11'b0};
    endfunction

    function automatic logic [31:0] i_ins(logic [5:0] op, logic [4:0] s1, logic [4:0] rt,
                                          logic [15:0] imm);
        return {op, s1, rt, imm};
    endfunction

    function automatic logic [31:0] j_ins(logic [5:0] op, logic [25:0] t);
        return {op, t};
    endfunction

    task automatic exp_trace(string name, logic [31:0] p, logic [1:0] c);
        sb_t e;
        e.name = name; e.kind = 0; e.idx = 0; e.exp_v = p; e.exp_c = c;
        sb_q.push_back(e);
    endtask

    task automatic exp_reg(string name, int idx, logic [31:0] v);
        sb_t e;
        e.name = name; e.kind = 1; e.idx = idx; e.exp_v = v; e.exp_c = 2'd0;
        sb_q.push_back(e);
    endtask

    task automatic exp_mem(string name, int idx, logic [31:0] v);
        sb_t e;
        e.name = name; e.kind = 2; e.idx = idx; e.exp_v = v; e.exp_c = 2'd0;
        sb_q.push_back(e);
    endtask

    // One clock edge, then drain the scoreboard against the post-edge state.
    task automatic step();
        sb_t e;
        logic [31:0] act;
        @(posedge clk1);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (e.kind == 0) begin
                if (pc !== e.exp_v || issue_cnt !== e.exp_c) begin
                    errors++;
                    $display("FAIL %s: pc=%0d issue_cnt=%0d, expected pc=%0d issue_cnt=%0d",
                             e.name, pc, issue_cnt, e.exp_v, e.exp_c);
                end
            end else begin
                act = (e.kind == 1) ? dut.REG[5'(e.idx)] : dut.MEM[11'(e.idx)];
                if (act !== e.exp_v) begin
                    errors++;
                    $display("FAIL %s: %s[%0d]=%h, expected %h", e.name,
                             (e.kind == 1) ? "REG" : "MEM", e.idx, act, e.exp_v);
                end
            end
        end
    endtask

    // Hold reset for one edge, then preload REG[i]=i and fill MEM with NOPs.
    task automatic begin_test(string name);
        reset = 1'b0;
        exp_trace({name, " reset"}, 32'd0, 2'd0);
        step();
        for (int i = 0; i < 1028; i++) dut.MEM[11'(i)] = NOP_W;
        for (int i = 0; i < 32; i++) dut.REG[5'(i)] = 32'(i);
    endtask

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{"add",  T_ADD,  1'b0, 32'd5,        32'd7,        32'd12};
        vecs[1]  = '{"sub",  T_SUB,  1'b0, 32'd5,        32'd7,        32'hFFFF_FFFE};
        vecs[2]  = '{"mul",  T_MUL,  1'b0, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001};
        vecs[3]  = '{"and",  T_AND,  1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234};
        vecs[4]  = '{"or",   T_OR,   1'b0, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F};
        vecs[5]  = '{"xor",  T_XOR,  1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F};
        vecs[6]  = '{"sll",  T_SLL,  1'b0, 32'd1,        32'h0000_0023, 32'd8};
        vecs[7]  = '{"srl",  T_SRL,  1'b0, 32'h8000_0000, 32'd31,       32'd1};
        vecs[8]  = '{"addi", T_ADDI, 1'b1, 32'd10,       32'h0000_FFFD, 32'd7};
        vecs[9]  = '{"subi", T_SUBI, 1'b1, 32'd10,       32'd20,       32'hFFFF_FFF6};
        vecs[10] = '{"andi", T_ANDI, 1'b1, 32'hFFFF_FFFF, 32'h0000_8001, 32'hFFFF_8001};
        vecs[11] = '{"ori",  T_ORI,  1'b1, 32'd0,        32'h0000_00F0, 32'h0000_00F0};
        vecs[12] = '{"xori", T_XORI, 1'b1, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFF_0000};
        vecs[13] = '{"undef", 6'b111110, 1'b0, 32'd1,    32'd2,        32'hDEAD_BEEF};

        // Reset held for two edges.
        begin_test("init");
        exp_trace("init reset2", 32'd0, 2'd0);
        step();

        // ALU table: one instruction at MEM[0], result in R3.
        for (int v = 0; v < 14; v++) begin
            begin_test(vecs[v].name);
            dut.REG[1] = vecs[v].a;
            dut.REG[2] = vecs[v].b;
            dut.REG[3] = 32'hDEAD_BEEF;
            dut.MEM[0] = vecs[v].is_imm ? i_ins(vecs[v].op, 5'd1, 5'd3, vecs[v].b[15:0])
                                        : r_ins(vecs[v].op, 5'd1, 5'd2, 5'd3);
            reset = 1'b1;
            exp_trace(vecs[v].name, 32'd2, 2'd2);
            exp_reg(vecs[v].name, 3, vecs[v].exp_v);
            step();
        end

        // Independent ADD program, all pairs dual-issue.
        begin_test("addprog");
        dut.MEM[0] = r_ins(T_ADD, 5'd1, 5'd2, 5'd14);
        dut.MEM[1] = r_ins(T_ADD, 5'd1, 5'd3, 5'd15);
        dut.MEM[2] = r_ins(T_ADD, 5'd1, 5'd14, 5'd16);
        dut.MEM[3] = r_ins(T_ADD, 5'd1, 5'd15, 5'd17);
        dut.MEM[4] = r_ins(T_ADD, 5'd1, 5'd14, 5'd18);
        dut.MEM[5] = r_ins(T_ADD, 5'd1, 5'd17, 5'd19);
        dut.MEM[6] = r_ins(T_ADD, 5'd1, 5'd18, 5'd20);
        dut.MEM[7] = r_ins(T_ADD, 5'd1, 5'd19, 5'd21);
        for (int i = 0; i < 8; i++) dut.MEM[11'(8 + i)] = r_ins(T_ADD, 5'd5, 5'(2 + i), 5'(14 + i));
        reset = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            exp_trace("addprog first", 32'(2 * i), 2'd2);
            if (i == 4) begin
                exp_reg("addprog mid", 14, 32'd3); exp_reg("addprog mid", 15, 32'd4);
                exp_reg("addprog mid", 16, 32'd4); exp_reg("addprog mid", 17, 32'd5);
                exp_reg("addprog mid", 18, 32'd4); exp_reg("addprog mid", 19, 32'd6);
                exp_reg("addprog mid", 20, 32'd5); exp_reg("addprog mid", 21, 32'd7);
            end
            step();
        end
        for (int i = 5; i <= 8; i++) begin
            exp_trace("addprog second", 32'(2 * i), 2'd2);
            if (i == 8) for (int r = 14; r <= 21; r++) exp_reg("addprog final", r, 32'(r - 7));
            step();
        end

        // Intra-pair RAW holds slot1.
        begin_test("raw");
        dut.MEM[0] = r_ins(T_ADD, 5'd1, 5'd2, 5'd5);
        dut.MEM[1] = r_ins(T_ADD, 5'd5, 5'd1, 5'd6);
        reset = 1'b1;
        exp_trace("raw held", 32'd1, 2'd1); exp_reg("raw r5", 5, 32'd3); exp_reg("raw r6", 6, 32'd6);
        step();
        exp_trace("raw second", 32'd3, 2'd2); exp_reg("raw r6b", 6, 32'd4);
        step();

        // Reset asserted mid-run suppresses that cycle's writeback.
        begin_test("midreset");
        dut.MEM[2] = i_ins(T_ADDI, 5'd0, 5'd10, 16'd77);
        reset = 1'b1;
        exp_trace("midreset run", 32'd2, 2'd2);
        step();
        reset = 1'b0;
        exp_trace("midreset edge", 32'd0, 2'd0); exp_reg("midreset nowrite", 10, 32'd10);
        step();
        reset = 1'b1;
        exp_trace("midreset again", 32'd2, 2'd2);
        step();
        exp_trace("midreset exec", 32'd4, 2'd2); exp_reg("midreset write", 10, 32'd77);
        step();

        // Store/load serialization, plus out-of-range accesses.
        begin_test("ldst");
        dut.MEM[0] = i_ins(T_SW, 5'd0, 5'd7, 16'd100);
        dut.MEM[1] = i_ins(T_LW, 5'd0, 5'd9, 16'd100);
        dut.MEM[3] = i_ins(T_SW, 5'd0, 5'd7, 16'd2000);
        dut.MEM[4] = i_ins(T_LW, 5'd0, 5'd11, 16'd2000);
        reset = 1'b1;
        exp_trace("ldst sw", 32'd1, 2'd1); exp_mem("ldst mem100", 100, 32'd7);
        step();
        exp_trace("ldst lw", 32'd3, 2'd2); exp_reg("ldst r9", 9, 32'd7);
        step();
        exp_trace("ldst oor pair", 32'd4, 2'd1);
        step();
        exp_trace("ldst oor lw", 32'd6, 2'd2); exp_reg("ldst oor r11", 11, 32'd0);
        step();

        // Branches: taken BEQ, untaken BNE, signed BLT taken, signed BGE untaken.
        begin_test("branch");
        dut.REG[23] = 32'hFFFF_FFFF;
        dut.MEM[0] = i_ins(T_BEQ, 5'd1, 5'd1, 16'd3);
        for (int i = 1; i <= 3; i++) dut.MEM[11'(i)] = i_ins(T_ADDI, 5'd0, 5'(19 + i), 16'd99);
        dut.MEM[4] = i_ins(T_BNE, 5'd1, 5'd1, 16'd5);
        dut.MEM[5] = i_ins(T_BLT, 5'd23, 5'd1, 16'd2);
        dut.MEM[6] = i_ins(T_ADDI, 5'd0, 5'd24, 16'd99);
        dut.MEM[7] = i_ins(T_ADDI, 5'd0, 5'd25, 16'd99);
        dut.MEM[8] = i_ins(T_BGE, 5'd23, 5'd1, 16'd1);
        reset = 1'b1;
        exp_trace("beq taken", 32'd4, 2'd1);
        step();
        exp_trace("bne untaken", 32'd5, 2'd1);
        step();
        exp_trace("blt signed", 32'd8, 2'd1);
        step();
        exp_trace("bge signed", 32'd9, 2'd1);
        step();
        exp_trace("after branches", 32'd11, 2'd2);
        for (int r = 20; r <= 22; r++) exp_reg("beq shadow", r, 32'(r));
        exp_reg("blt shadow", 24, 32'd24); exp_reg("blt shadow", 25, 32'd25);
        step();

        // JAL, R0 write, J in slot1, WAW in a pair, fetch past end of memory.
        begin_test("jal");
        dut.MEM[0]  = i_ins(T_ADDI, 5'd0, 5'd0, 16'd5);
        dut.MEM[2]  = j_ins(T_JAL, 26'd20);
        dut.MEM[3]  = i_ins(T_ADDI, 5'd0, 5'd24, 16'd1);
        dut.MEM[20] = i_ins(T_ADDI, 5'd0, 5'd25, 16'hFFFB);
        dut.MEM[21] = j_ins(T_J, 26'd40);
        dut.MEM[40] = i_ins(T_ADDI, 5'd0, 5'd26, 16'd1);
        dut.MEM[41] = i_ins(T_ADDI, 5'd0, 5'd26, 16'd2);
        dut.MEM[42] = j_ins(T_J, 26'd1027);
        dut.MEM[1027] = i_ins(T_ADDI, 5'd0, 5'd27, 16'd5);
        reset = 1'b1;
        exp_trace("r0 pair", 32'd2, 2'd2); exp_reg("r0 write", 0, 32'd0);
        step();
        exp_trace("jal", 32'd20, 2'd1); exp_reg("jal r31", 31, 32'd3);
        step();
        exp_trace("j slot1", 32'd40, 2'd2); exp_reg("jal shadow", 24, 32'd24);
        exp_reg("addi neg", 25, 32'hFFFF_FFFB);
        step();
        exp_trace("waw pair", 32'd42, 2'd2); exp_reg("waw r26", 26, 32'd2);
        step();
        exp_trace("j end", 32'd1027, 2'd1);
        step();
        exp_trace("last word", 32'd1029, 2'd2); exp_reg("last word r27", 27, 32'd5);
        step();
        exp_trace("past end", 32'd1031, 2'd2);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
